// File: rtl/alu_mc.sv
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU with START/BUSY/DONE handshake, iterative shifts
//            and optional iterative multiply (enabled by ALU_MC_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_mc #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] datain1,
    input  logic [WIDTH-1:0] datain2,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    // Counter must hold WIDTH for the multiply, one bit wider than a shift amount
    localparam int               CNT_W   = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
`ifdef ALU_MC_MUL_EN
        , S_MUL = 2'd2
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] sh_q;

    logic [WIDTH:0]     add_full;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic               go_shift;
    logic               go_mul;
    logic               last;

    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_illegal;

    logic [WIDTH-1:0] sh_next;
    logic             sh_out;

    logic             fin;
    logic [WIDTH-1:0] fin_res;
    logic             fin_carry;
    logic             fin_ovf;
    logic             fin_ill;

    assign add_full = {1'b0, datain1} + {1'b0, datain2};
    assign shamt    = datain2[SHAMT_W-1:0];
    assign is_shift = (select == OP_SLL) || (select == OP_SRL) || (select == OP_SRA);
    assign go_shift = is_shift && (shamt != '0);
    assign last     = (cnt == CNT_ONE);

`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] prod_hi_q;
    logic [WIDTH-1:0] prod_lo_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    assign go_mul      = (select == 3'b111);
    assign mul_sum     = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], prod_lo_q[WIDTH-1:1]};
`else
    assign go_mul = 1'b0;
`endif

    // Results of the ops that complete on the start edge (shift by 0 passes A through)
    always_comb begin
        sc_res     = '0;
        sc_carry   = 1'b0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        case (select)
            OP_FWD: sc_res = datain2;
            OP_ADD: begin
                sc_res   = add_full[WIDTH-1:0];
                sc_carry = add_full[WIDTH];
                sc_ovf   = (datain1[WIDTH-1] == datain2[WIDTH-1]) &&
                           (add_full[WIDTH-1] != datain1[WIDTH-1]);
            end
            OP_AND: sc_res = datain1 & datain2;
            OP_OR:  sc_res = datain1 | datain2;
            OP_SLL, OP_SRL, OP_SRA: sc_res = datain1;
            default: begin
`ifndef ALU_MC_MUL_EN
                sc_illegal = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        sh_next = sh_q;
        sh_out  = 1'b0;
        case (op_q)
            OP_SLL: begin
                sh_next = {sh_q[WIDTH-2:0], 1'b0};
                sh_out  = sh_q[WIDTH-1];
            end
            OP_SRL: begin
                sh_next = {1'b0, sh_q[WIDTH-1:1]};
                sh_out  = sh_q[0];
            end
            default: begin
                sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                sh_out  = sh_q[0];
            end
        endcase
    end

    always_comb begin
        fin       = 1'b0;
        fin_res   = sc_res;
        fin_carry = sc_carry;
        fin_ovf   = sc_ovf;
        fin_ill   = sc_illegal;
        case (state)
            S_IDLE: fin = start && !go_shift && !go_mul;
            S_SHIFT: begin
                fin       = last;
                fin_res   = sh_next;
                fin_carry = sh_out;
                fin_ovf   = 1'b0;
                fin_ill   = 1'b0;
            end
`ifdef ALU_MC_MUL_EN
            S_MUL: begin
                fin       = last;
                fin_res   = mul_lo_next;
                fin_carry = |mul_hi_next;
                fin_ovf   = 1'b0;
                fin_ill   = 1'b0;
            end
`endif
            default: fin = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= '0;
            sh_q    <= '0;
            result  <= '0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            carry   <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
`ifdef ALU_MC_MUL_EN
            mcand_q   <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
`endif
        end else begin
            done <= fin;
            if (fin) begin
                result  <= fin_res;
                zero    <= (fin_res == '0);
                neg     <= fin_res[WIDTH-1];
                carry   <= fin_carry;
                ovf     <= fin_ovf;
                illegal <= fin_ill;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= select;
                        if (go_shift) begin
                            state <= S_SHIFT;
                            busy  <= 1'b1;
                            cnt   <= {1'b0, shamt};
                            sh_q  <= datain1;
                        end
`ifdef ALU_MC_MUL_EN
                        else if (go_mul) begin
                            state     <= S_MUL;
                            busy      <= 1'b1;
                            cnt       <= CNT_W'(WIDTH);
                            mcand_q   <= datain1;
                            prod_hi_q <= '0;
                            prod_lo_q <= datain2;
                        end
`endif
                    end
                end
                S_SHIFT: begin
                    sh_q <= sh_next;
                    cnt  <= cnt - CNT_ONE;
                    if (last) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
`ifdef ALU_MC_MUL_EN
                S_MUL: begin
                    prod_hi_q <= mul_hi_next;
                    prod_lo_q <= mul_lo_next;
                    cnt       <= cnt - CNT_ONE;
                    if (last) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Directed self-checking bench for alu_mc (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_mc;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] select;
    logic [7:0] datain1;
    logic [7:0] datain2;
    logic [7:0] result;
    logic       zero, neg, carry, ovf, busy, done, illegal;
    logic [6:0] flags;

    int vectors;
    int miscompares;
    int n;
    int seen;

    alu_mc #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .select  (select),
        .datain1 (datain1),
        .datain2 (datain2),
        .result  (result),
        .zero    (zero),
        .neg     (neg),
        .carry   (carry),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done),
        .illegal (illegal)
    );

    // flag vector order: zero neg carry ovf busy done illegal
    assign flags = {zero, neg, carry, ovf, busy, done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request for exactly one edge, then scrambles inputs to
    // show that captured copies are used.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start   = 1'b1;
        select  = op;
        datain1 = a;
        datain2 = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        select  = ~op;
        datain1 = ~a;
        datain2 = ~b;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        select  = 3'b000;
        datain1 = 8'h00;
        datain2 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", 16'(result), 16'h00);
        chk("reset_flags",  16'(flags),  16'h00);
        @(negedge clk);
        rst_n = 1'b1;

        issue(3'b001, 8'h7F, 8'h01);
        wait_done(n);
        chk("add_ovf_lat",   16'(n),      16'd0);
        chk("add_ovf_res",   16'(result), 16'h80);
        chk("add_ovf_flags", 16'(flags),  16'(7'b0101010));
        @(posedge clk); #1;
        chk("done_pulse", 16'(done), 16'h0);

        issue(3'b001, 8'hFF, 8'h01);
        wait_done(n);
        chk("add_wrap_res",   16'(result), 16'h00);
        chk("add_wrap_flags", 16'(flags),  16'(7'b1010010));

        issue(3'b000, 8'h33, 8'h5A);
        wait_done(n);
        chk("fwd_res",   16'(result), 16'h5A);
        chk("fwd_flags", 16'(flags),  16'(7'b0000010));

        issue(3'b010, 8'hF0, 8'h3C);
        wait_done(n);
        chk("and_res", 16'(result), 16'h30);

        issue(3'b011, 8'hF0, 8'h0C);
        wait_done(n);
        chk("or_res",   16'(result), 16'hFC);
        chk("or_flags", 16'(flags),  16'(7'b0100010));

        issue(3'b110, 8'h90, 8'h03);
        chk("sra_busy", 16'({busy, done}), 16'(2'b10));
        wait_done(n);
        chk("sra_lat",   16'(n),      16'd3);
        chk("sra_res",   16'(result), 16'hF2);
        chk("sra_flags", 16'(flags),  16'(7'b0100010));

        issue(3'b100, 8'h81, 8'h01);
        wait_done(n);
        chk("sll_lat",   16'(n),      16'd1);
        chk("sll_res",   16'(result), 16'h02);
        chk("sll_flags", 16'(flags),  16'(7'b0010010));

        issue(3'b101, 8'h81, 8'h02);
        wait_done(n);
        chk("srl_lat",   16'(n),      16'd2);
        chk("srl_res",   16'(result), 16'h20);
        chk("srl_flags", 16'(flags),  16'(7'b0000010));

        // Amount field is zero (only low bits of B count): single-cycle, CARRY=0
        issue(3'b100, 8'hA5, 8'h08);
        wait_done(n);
        chk("sll0_lat",   16'(n),      16'd0);
        chk("sll0_res",   16'(result), 16'hA5);
        chk("sll0_flags", 16'(flags),  16'(7'b0100010));

`ifdef ALU_MC_MUL_EN
        issue(3'b111, 8'd13, 8'd11);
        chk("mul_busy", 16'(busy), 16'h1);
        wait_done(n);
        chk("mul_lat",   16'(n),      16'd8);
        chk("mul_res",   16'(result), 16'h8F);
        chk("mul_flags", 16'(flags),  16'(7'b0100010));

        issue(3'b111, 8'h10, 8'h10);
        wait_done(n);
        chk("mul_hi_res",   16'(result), 16'h00);
        chk("mul_hi_flags", 16'(flags),  16'(7'b1010010));

        issue(3'b111, 8'd13, 8'd11);
        issue(3'b001, 8'h01, 8'h01);
        wait_done(n);
        chk("mul_ign_lat", 16'(n + 1),  16'd8);
        chk("mul_ign_res", 16'(result), 16'h8F);
        @(posedge clk); #1;
        chk("mul_ign_single", 16'(done), 16'h0);
`else
        issue(3'b111, 8'd13, 8'd11);
        wait_done(n);
        chk("ill_lat",   16'(n),      16'd0);
        chk("ill_res",   16'(result), 16'h00);
        chk("ill_flags", 16'(flags),  16'(7'b1000011));

        issue(3'b001, 8'h01, 8'h01);
        wait_done(n);
        chk("ill_clr_res",   16'(result), 16'h02);
        chk("ill_clr_flags", 16'(flags),  16'(7'b0000010));
`endif

        // START during BUSY is dropped; no second DONE follows
        issue(3'b101, 8'h80, 8'h04);
        issue(3'b000, 8'h00, 8'hFF);
        wait_done(n);
        chk("ign_lat",   16'(n + 1),  16'd4);
        chk("ign_res",   16'(result), 16'h08);
        chk("ign_flags", 16'(flags),  16'(7'b0000010));
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("ign_no_second_done", 16'(seen), 16'd0);

        // Asynchronous reset in the middle of a multi-cycle op
`ifdef ALU_MC_MUL_EN
        issue(3'b111, 8'd13, 8'd11);
`else
        issue(3'b110, 8'h80, 8'h07);
`endif
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_result", 16'(result), 16'h00);
        chk("abort_flags",  16'(flags),  16'h00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_quiet", 16'(seen), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
